// File: rtl/hex_display_scanner_if.sv
// Bus between the adder datapath and the seven-segment scanner.
// The datapath side drives the digit payload; the display side returns pins.
interface hex_display_scanner_if;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_sel;

  modport master (output digits, dp_in, blank, load,
                  input  seg, dp, an, digit_sel);
  modport slave  (input  digits, dp_in, blank, load,
                  output seg, dp, an, digit_sel);
endinterface

// File: rtl/hex_display_scanner.sv
// Four-digit multiplexed seven-segment driver: latches hex/dp/blank on load,
// scans anodes with a blanking gap at the start of each slot.
module hex_display_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP         = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hex_display_scanner_if.slave bus
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_C = CW'(GAP);

  typedef enum logic {ST_BLANK, ST_ON} state_e;
  localparam state_e RST_ST = (GAP == 0) ? ST_ON : ST_BLANK;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'b1000000;
      4'h1: hex2seg = 7'b1111001;
      4'h2: hex2seg = 7'b0100100;
      4'h3: hex2seg = 7'b0110000;
      4'h4: hex2seg = 7'b0011001;
      4'h5: hex2seg = 7'b0010010;
      4'h6: hex2seg = 7'b0000010;
      4'h7: hex2seg = 7'b1111000;
      4'h8: hex2seg = 7'b0000000;
      4'h9: hex2seg = 7'b0010000;
      4'hA: hex2seg = 7'b0001000;
      4'hB: hex2seg = 7'b0000011;
      4'hC: hex2seg = 7'b1000110;
      4'hD: hex2seg = 7'b0100001;
      4'hE: hex2seg = 7'b0000110;
      default: hex2seg = 7'b0001110;
    endcase
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  state_e        state_q, state_d;
  logic [15:0]   digits_q, digits_d;
  logic [3:0]    dpl_q, dpl_d;
  logic [3:0]    blank_q, blank_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          wrap, lit;

  always_comb begin
    wrap     = (cnt_q == LAST);
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    sel_d    = sel_q + {1'b0, wrap};
    digits_d = bus.load ? bus.digits : digits_q;
    dpl_d    = bus.load ? bus.dp_in  : dpl_q;
    blank_d  = bus.load ? bus.blank  : blank_q;

    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_d == GAP_C)        state_d = ST_ON;
      ST_ON:    if (wrap && (GAP != 0))    state_d = ST_BLANK;
      default:                             state_d = RST_ST;
    endcase

    // Outputs are built from the next slot/state so anode and segments
    // switch together; the latch is used as already registered.
    lit  = (state_d == ST_ON) && !blank_q[sel_d];
    an_d = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(4'b0001 << sel_d);
      seg_d = hex2seg(digits_q[{sel_d, 2'b00} +: 4]);
      dp_d  = ~dpl_q[sel_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sel_q    <= '0;
      state_q  <= RST_ST;
      digits_q <= '0;
      dpl_q    <= '0;
      blank_q  <= '0;
      an_q     <= 4'hF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      state_q  <= state_d;
      digits_q <= digits_d;
      dpl_q    <= dpl_d;
      blank_q  <= blank_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.digit_sel = sel_q;
endmodule
